// File: rtl/alu_pkg.sv
// alu_pkg: op and state encodings shared by the execute ALU and its iterative mul/div unit.
package alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [4:0] OP_LAST = 5'd17;

    function automatic logic is_muldiv(logic [4:0] op);
        return op >= OP_MUL && op <= OP_LAST;
    endfunction

    // Ops whose out_less flag compares the operands as unsigned
    function automatic logic is_unsigned_cmp(logic [4:0] op);
        return op == OP_SLTU || op == OP_DIVU || op == OP_REMU || op == OP_MULHU;
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: XLEN-step shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up and divide-by-zero handling applied to the final registers.
module muldiv_iter import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi, lo, m, a_q;
    logic [4:0]      op_q;
    logic            sa, sb, bz, busy;
    logic [CW-1:0]   cnt;
    logic            a_sgn, b_sgn, cur_div, dge;
    logic [XLEN-1:0] cur_hi, cur_lo, cur_m, step_hi, step_lo, div_hi;
    logic [XLEN:0]   msum, dsh;
    logic [2*XLEN-1:0] prod, pfix;
    logic [XLEN-1:0] qfix, rfix;

    assign a_sgn = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_sgn = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);

    // The start cycle already performs the first step on the freshly loaded magnitudes
    assign cur_div = start ? op >= OP_DIV : op_q >= OP_DIV;
    assign cur_hi  = start ? '0 : hi;
    assign cur_lo  = start ? (a_sgn ? -a : a) : lo;
    assign cur_m   = start ? (b_sgn ? -b : b) : m;

    assign msum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_m} : '0);
    assign dsh     = {cur_hi, cur_lo[XLEN-1]};
    assign dge     = dsh >= {1'b0, cur_m};
    assign div_hi  = dge ? dsh[XLEN-1:0] - cur_m : dsh[XLEN-1:0];
    assign step_hi = cur_div ? div_hi : msum[XLEN:1];
    assign step_lo = cur_div ? {cur_lo[XLEN-2:0], dge} : {msum[0], cur_lo[XLEN-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            m    <= '0;
            a_q  <= '0;
            op_q <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            bz   <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(1);
            hi   <= step_hi;
            lo   <= step_lo;
            m    <= cur_m;
            a_q  <= a;
            op_q <= op;
            sa   <= a_sgn;
            sb   <= b_sgn;
            bz   <= b == '0;
        end else if (busy) begin
            hi   <= step_hi;
            lo   <= step_lo;
            cnt  <= cnt + 1'b1;
            busy <= cnt != CW'(XLEN-1);
        end
    end

    assign done = !busy;
    assign prod = {hi, lo};
    assign pfix = (sa ^ sb) ? -prod : prod;
    assign qfix = (sa ^ sb) ? -lo : lo;
    assign rfix = sa ? -hi : hi;

    assign result = op_q == OP_MUL ? pfix[XLEN-1:0] :
                    op_q <  OP_DIV ? pfix[2*XLEN-1:XLEN] :
                    op_q <  OP_REM ? (bz ? '1 : qfix) :
                                     (bz ? a_q : rfix);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I/RV32M execute ALU; single-cycle base ops, iterative mul/div,
// one operation in flight at a time.
module alu_seq import alu_pkg::*; #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_less,
    output logic            out_illegal
);
    localparam int SW = $clog2(XLEN);

    state_e          state, state_n;
    logic [SW-1:0]   count;
    logic [4:0]      op_q, op;
    logic [XLEN-1:0] a_q, b_q, a, b;
    logic            accept, md_start, md_done, is_md, illegal, less;
    logic [XLEN-1:0] md_result, alu_res, res;
    logic [SW-1:0]   shamt;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;

    // Evaluate on the live inputs in the accept cycle, on the held operands afterwards
    assign op       = accept ? in_op : op_q;
    assign a        = accept ? in_a : a_q;
    assign b        = accept ? in_b : b_q;
    assign shamt    = b[SW-1:0];
    assign is_md    = is_muldiv(op) && MULDIV_EN;
    assign illegal  = op > OP_LAST || (is_muldiv(op) && !MULDIV_EN);
    assign md_start = accept & is_md;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    assign less = illegal ? 1'b0 : is_unsigned_cmp(op) ? a < b : $signed(a) < $signed(b);
    assign res  = illegal ? '0 : is_md ? md_result : alu_res;

    generate
        if (MULDIV_EN) begin : g_md
            muldiv_iter #(.XLEN(XLEN)) u_md (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (md_start),
                .op     (in_op),
                .a      (in_a),
                .b      (in_b),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_nomd
            assign md_done   = 1'b1;
            assign md_result = '0;
        end
    endgenerate

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (md_start ? BUSY : DONE) : IDLE;
            BUSY:    state_n = (count == SW'(XLEN-1) && md_done) ? DONE : BUSY;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_less    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_n;
            count <= state == BUSY ? count + 1'b1 : '0;
            if (accept) begin
                op_q <= in_op;
                a_q  <= in_a;
                b_q  <= in_b;
            end
            if (state != DONE && state_n == DONE) begin
                out_result  <= res;
                out_zero    <= res == '0;
                out_less    <= less;
                out_illegal <= illegal;
            end
        end
    end
endmodule
